// File: rtl/sound_pkg.sv
// Shared types, note half-periods and cue note tables for the sound cue sequencer.
package sound_pkg;

  typedef enum logic [1:0] {CUE_NONE, CUE_HIT, CUE_START, CUE_END} cue_e;

  typedef enum logic [1:0] {StIdle, StNote, StGap} state_e;

  localparam int unsigned HalfW = 17;

  localparam logic [HalfW-1:0] HalfC5 = 17'd95557;
  localparam logic [HalfW-1:0] HalfE5 = 17'd75844;
  localparam logic [HalfW-1:0] HalfG5 = 17'd63776;
  localparam logic [HalfW-1:0] HalfC6 = 17'd47778;

  function automatic logic [1:0] cue_len(cue_e cue, logic god);
    case (cue)
      CUE_START, CUE_END: return 2'd3;
      CUE_HIT:            return god ? 2'd2 : 2'd1;
      default:            return 2'd0;
    endcase
  endfunction

  function automatic logic [HalfW-1:0] cue_note(cue_e cue, logic [1:0] idx, logic god);
    case (cue)
      CUE_START: return (idx == 2'd0) ? HalfC5 : (idx == 2'd1) ? HalfE5 : HalfG5;
      CUE_END:   return (idx == 2'd0) ? HalfG5 : (idx == 2'd1) ? HalfE5 : HalfC5;
      CUE_HIT:   return (god && idx == 2'd0) ? HalfG5 : HalfC6;
      default:   return '0;
    endcase
  endfunction

  function automatic cue_e cue_max(cue_e a, cue_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tone_div.sv
// Loadable half-period down-counter; ticks on the first running cycle after a load and then
// once every period cycles.
module tone_div #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] period_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] reload;

  // A zero period degenerates to a tick every cycle.
  assign reload = (period_q == '0) ? '0 : period_q - W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      period_q <= period;
      cnt_q    <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == '0) ? reload : cnt_q - W'(1);
    end
  end

  assign tick = run && (cnt_q == '0);

endmodule

// File: rtl/sound_cue_seq.sv
// Turns game events into note sequences of half-period strobes for the speaker toggler.
// Define CUE_PENDING_EN to keep one dropped lower-priority cue and play it after the current one.
module sound_cue_seq
  import sound_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 5_000_000,
  parameter int unsigned GAP_TICKS  = 1_000_000,
  parameter int unsigned DIV_SHIFT  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic hit_evt,
  input  logic start_evt,
  input  logic end_evt,
  input  logic god_mode,
  output logic enable,
  output logic start_enable,
  output logic end_enable,
  output logic busy
);

  localparam int unsigned DurMax = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int unsigned DurW   = (DurMax > 2) ? $clog2(DurMax) : 1;
  localparam logic [DurW-1:0] NoteLast = DurW'(NOTE_TICKS - 1);
  localparam logic [DurW-1:0] GapLast  = DurW'(GAP_TICKS - 1);

  state_e           state_q;
  cue_e             cue_q;
  logic             god_q;
  logic [1:0]       note_idx_q;
  logic [DurW-1:0]  dur_q;

  cue_e             evt_cue, new_cue, pend_merge;
  logic             accept_evt, note_done, gap_done, last_note, finish, pend_take, go;
  logic             load, tick;
  logic [HalfW-1:0] load_half;

  always_comb begin
    evt_cue = CUE_NONE;
    if (end_evt)        evt_cue = CUE_END;
    else if (start_evt) evt_cue = CUE_START;
    else if (hit_evt)   evt_cue = CUE_HIT;
  end

  // cue_q is CUE_NONE while idle, so any event is accepted then.
  assign accept_evt = (evt_cue != CUE_NONE) && (evt_cue >= cue_q);
  assign note_done  = (state_q == StNote) && (dur_q == NoteLast);
  assign gap_done   = (state_q == StGap) && (dur_q == GapLast);
  assign last_note  = (note_idx_q == cue_len(cue_q, god_q) - 2'd1);
  assign finish     = note_done && last_note;

`ifdef CUE_PENDING_EN
  cue_e pend_q, second_cue;

  always_comb begin
    second_cue = CUE_NONE;
    if (end_evt && start_evt)                      second_cue = CUE_START;
    else if ((end_evt || start_evt) && hit_evt)    second_cue = CUE_HIT;
  end

  // Every event that is not the accepted one competes for the slot.
  assign pend_merge = cue_max(pend_q, accept_evt ? second_cue : evt_cue);
  assign pend_take  = finish && !accept_evt && (pend_merge != CUE_NONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pend_q <= CUE_NONE;
    else if (pend_take) pend_q <= CUE_NONE;
    else                pend_q <= pend_merge;
  end
`else
  assign pend_merge = CUE_NONE;
  assign pend_take  = 1'b0;
`endif

  assign go        = accept_evt || pend_take;
  assign new_cue   = accept_evt ? evt_cue : pend_merge;
  assign load      = go || gap_done;
  assign load_half = go ? cue_note(new_cue, 2'd0, god_mode)
                        : cue_note(cue_q, note_idx_q + 2'd1, god_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cue_q      <= CUE_NONE;
      god_q      <= 1'b0;
      note_idx_q <= '0;
      dur_q      <= '0;
    end else if (go) begin
      state_q    <= StNote;
      cue_q      <= new_cue;
      god_q      <= god_mode;
      note_idx_q <= '0;
      dur_q      <= '0;
    end else begin
      case (state_q)
        StNote: begin
          if (note_done) begin
            dur_q <= '0;
            if (last_note) begin
              state_q <= StIdle;
              cue_q   <= CUE_NONE;
            end else begin
              state_q <= StGap;
            end
          end else begin
            dur_q <= dur_q + DurW'(1);
          end
        end
        StGap: begin
          if (gap_done) begin
            dur_q      <= '0;
            state_q    <= StNote;
            note_idx_q <= note_idx_q + 2'd1;
          end else begin
            dur_q <= dur_q + DurW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  tone_div #(
    .W (HalfW)
  ) u_tone_div (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .run    (state_q == StNote),
    .period (load_half >> DIV_SHIFT),
    .tick   (tick)
  );

  assign enable       = tick && (cue_q == CUE_HIT);
  assign start_enable = tick && (cue_q == CUE_START);
  assign end_enable   = tick && (cue_q == CUE_END);
  assign busy         = (state_q != StIdle);

endmodule
